// File: rtl/frame_sequencer_pkg.sv
// Shared types and defaults for the frame sequencer.
// The optional load watchdog is enabled with FRAME_SEQUENCER_TIMEOUT_EN.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOADING,
    S_WAIT_DELAY,
    S_WAIT_SWAP
  } state_t;

  localparam logic [23:0] DEF_BASE_ADDR       = 24'h100000;
  localparam int unsigned DEF_FRAME_BYTES     = 8192;
  localparam int unsigned DEF_WORDS_PER_FRAME = 4096;

  localparam int unsigned           TIMEOUT_W    = 21;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'((1 << 20) - 1);

  // Wraps after the last frame; an index already past the end also restarts at 0.
  function automatic logic [7:0] next_frame_index(input logic [7:0] idx,
                                                  input logic [7:0] count);
    if (count == 8'd0 || idx >= count - 8'd1) return 8'd0;
    return idx + 8'd1;
  endfunction

endpackage

// File: rtl/frame_delay_timer.sv
// Saturating cycle counter with synchronous clear and a >= threshold flag,
// used to enforce the minimum time between load issue and bank swap.
module frame_delay_timer #(
  parameter int unsigned W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic [W-1:0] i_threshold,
  output logic         o_reached
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign o_reached = (count >= i_threshold);

endmodule

// File: rtl/frame_sequencer.sv
// Double-buffered animation sequencer: requests frame loads from flash, counts
// RAM write strobes, and swaps banks on vsync. Watchdog: FRAME_SEQUENCER_TIMEOUT_EN.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int unsigned FRAME_BYTES     = DEF_FRAME_BYTES,
  parameter int unsigned WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  input  logic [7:0]   i_frame_count,
  input  logic [23:0]  i_frame_delay,
  input  logic         i_vsync,
  input  logic         i_ram_write_en,
  output logic [23:0]  o_read_addr,
  output logic         o_read_stb,
  output logic         o_load_bank,
  output logic         o_display_bank,
  output logic [7:0]   o_frame_index,
  output logic         o_busy,
  output logic         o_error,
  output state_t       o_state
);

  localparam logic [12:0] LAST_WORD    = 13'(WORDS_PER_FRAME - 1);
  localparam logic [23:0] FRAME_STRIDE = 24'(FRAME_BYTES);

  state_t      state, state_n;
  logic [7:0]  frame_index, frame_index_n;
  logic        load_bank, load_bank_n;
  logic [12:0] word_cnt;
  logic        load_done;
  logic        delay_reached;
  logic        wd_expire;
  logic [23:0] read_addr;
  logic        read_stb;

  // Loader handshake: o_read_stb is a one-cycle request with no ready; the
  // loader must accept it, and o_read_addr is stable from the strobe onward.
  assign load_done = (state == S_LOADING) && i_ram_write_en && (word_cnt == LAST_WORD);

  always_comb begin
    state_n       = state;
    frame_index_n = frame_index;
    load_bank_n   = load_bank;
    case (state)
      S_IDLE: begin
        if (i_enable && i_frame_count != 8'd0) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        state_n = S_LOADING;
      end
      S_LOADING: begin
        if (load_done)      state_n = S_WAIT_DELAY;
        else if (wd_expire) state_n = S_ISSUE;
      end
      S_WAIT_DELAY: begin
        if (delay_reached) state_n = S_WAIT_SWAP;
      end
      S_WAIT_SWAP: begin
        if (i_vsync) begin
          load_bank_n   = ~load_bank;
          frame_index_n = next_frame_index(frame_index, i_frame_count);
          state_n       = i_enable ? S_ISSUE : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobe and address are registered from the next state so they line up
  // exactly with the S_ISSUE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      frame_index <= 8'd0;
      load_bank   <= 1'b1;
      read_stb    <= 1'b0;
      read_addr   <= 24'd0;
    end else begin
      state       <= state_n;
      frame_index <= frame_index_n;
      load_bank   <= load_bank_n;
      read_stb    <= (state_n == S_ISSUE);
      if (state_n == S_ISSUE) begin
        read_addr <= BASE_ADDR + 24'(frame_index_n) * FRAME_STRIDE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt <= 13'd0;
    end else if (state == S_ISSUE) begin
      word_cnt <= 13'd0;
    end else if (state == S_LOADING && i_ram_write_en) begin
      word_cnt <= word_cnt + 13'd1;
    end
  end

  frame_delay_timer #(.W(24)) u_delay_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (state == S_ISSUE),
    .i_threshold (i_frame_delay),
    .o_reached   (delay_reached)
  );

`ifdef FRAME_SEQUENCER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 error_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_LOADING) ? wd_cnt + 1'b1 : '0;
      if (wd_expire) error_q <= 1'b1;
    end
  end

  // A stalled load is reissued for the same frame; the error stays latched.
  assign wd_expire = (state == S_LOADING) && !load_done && (wd_cnt == TIMEOUT_LAST);
  assign o_error   = error_q;
`else
  assign wd_expire = 1'b0;
  assign o_error   = 1'b0;
`endif

  assign o_read_addr    = read_addr;
  assign o_read_stb     = read_stb;
  assign o_load_bank    = load_bank;
  assign o_display_bank = ~load_bank;
  assign o_frame_index  = frame_index;
  assign o_busy         = (state != S_IDLE);
  assign o_state        = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: load requests are checked by a monitor
// against an expected queue of {load_bank, frame_index, read_addr}.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int W = 33;
`ifdef FRAME_SEQUENCER_TIMEOUT_EN
  localparam longint MAX_CYCLES = 1_300_000;
`else
  localparam longint MAX_CYCLES = 90_000;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic [7:0]  i_frame_count;
  logic [23:0] i_frame_delay;
  logic        i_vsync;
  logic        i_ram_write_en;
  logic [23:0] o_read_addr;
  logic        o_read_stb;
  logic        o_load_bank;
  logic        o_display_bank;
  logic [7:0]  o_frame_index;
  logic        o_busy;
  logic        o_error;
  state_t      o_state;

  logic [W-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  frame_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_frame_count  (i_frame_count),
    .i_frame_delay  (i_frame_delay),
    .i_vsync        (i_vsync),
    .i_ram_write_en (i_ram_write_en),
    .o_read_addr    (o_read_addr),
    .o_read_stb     (o_read_stb),
    .o_load_bank    (o_load_bank),
    .o_display_bank (o_display_bank),
    .o_frame_index  (o_frame_index),
    .o_busy         (o_busy),
    .o_error        (o_error),
    .o_state        (o_state)
  );

  // Clock and global time bound
  always #5 i_clk = ~i_clk;

  initial begin
    #(MAX_CYCLES * 10);
    $display("FAIL global_timeout: simulation did not finish within %0d cycles", MAX_CYCLES);
    $fatal(1, "time limit");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_load(input logic bank, input logic [7:0] idx, input logic [23:0] addr);
    exp_q.push_back({bank, idx, addr});
  endtask

  task automatic wait_stb(input int budget);
    int n = 0;
    while (o_read_stb !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("read_stb_wait", {31'd0, o_read_stb}, 32'd1);
  endtask

  task automatic load_words(input int n, input int gap, input int drop_at);
    for (int i = 0; i < n; i++) begin
      i_ram_write_en = 1'b1;
      if (i == drop_at) i_enable = 1'b0;
      tick();
      i_ram_write_en = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic pulse_vsync();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
  endtask

  task automatic check_swap(input logic prev_bank);
    check("load_bank_toggled", {31'd0, o_load_bank}, {31'd0, ~prev_bank});
    check("display_bank_follows", {31'd0, o_display_bank}, {31'd0, prev_bank});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_read_stb"}, {31'd0, o_read_stb}, 32'd0);
    check({tag, "_read_addr"}, {8'd0, o_read_addr}, 32'd0);
    check({tag, "_load_bank"}, {31'd0, o_load_bank}, 32'd1);
    check({tag, "_display_bank"}, {31'd0, o_display_bank}, 32'd0);
    check({tag, "_frame_index"}, {24'd0, o_frame_index}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_error"}, {31'd0, o_error}, 32'd0);
    check({tag, "_state"}, 32'(o_state), 32'(S_IDLE));
  endtask

  // Scoreboard monitor: every load request must match the head of exp_q
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_read_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read_stb: addr 0x%0h index %0d, expected no request",
                 o_read_addr, o_frame_index);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("read_addr", {8'd0, o_read_addr}, {8'd0, e[23:0]});
        check("frame_index", {24'd0, o_frame_index}, {24'd0, e[31:24]});
        check("load_bank_at_issue", {31'd0, o_load_bank}, {31'd0, e[32]});
      end
    end
  end

  // Stimulus
  initial begin
    logic prev;
    logic busy_any;
    i_rst_n        = 1'b0;
    i_enable       = 1'b0;
    i_frame_count  = 8'd0;
    i_frame_delay  = 24'd0;
    i_vsync        = 1'b0;
    i_ram_write_en = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    i_rst_n = 1'b1;
    tick();

    // Nothing to play: stays idle, no requests
    i_enable = 1'b1;
    busy_any = 1'b0;
    repeat (10000) begin
      tick();
      busy_any |= o_busy;
    end
    check("count0_busy", {31'd0, busy_any}, 32'd0);
    i_enable = 1'b0;
    tick();

    // Three-frame loop, zero delay, wraps back to frame 0
    i_frame_count = 8'd3;
    expect_load(1'b1, 8'd0, 24'h100000);
    expect_load(1'b0, 8'd1, 24'h102000);
    expect_load(1'b1, 8'd2, 24'h104000);
    expect_load(1'b0, 8'd0, 24'h100000);
    i_enable = 1'b1;
    tick();
    check("enable_latency", {31'd0, o_read_stb}, 32'd1);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) wait_stb(50);
      tick();
      load_words(4096, 0, -1);
      tick();
      if (f == 0) check("state_wait_swap", 32'(o_state), 32'(S_WAIT_SWAP));
      if (f == 3) i_enable = 1'b0;
      prev = o_load_bank;
      pulse_vsync();
      check_swap(prev);
    end
    check("loop_end_idle", 32'(o_state), 32'(S_IDLE));
    check("loop_end_busy", {31'd0, o_busy}, 32'd0);
    check("loop_end_index", {24'd0, o_frame_index}, 32'd1);

    // Minimum delay: early vsync ignored, later vsync swaps
    i_frame_delay = 24'd20000;
    expect_load(1'b1, 8'd1, 24'h102000);
    i_enable = 1'b1;
    wait_stb(5);
    tick();
    load_words(4096, 1, -1);
    repeat (9000 - 8193) tick();
    check("delay_state_early", 32'(o_state), 32'(S_WAIT_DELAY));
    prev = o_load_bank;
    pulse_vsync();
    check("early_vsync_no_swap", {31'd0, o_load_bank}, {31'd0, prev});
    check("early_vsync_index", {24'd0, o_frame_index}, 32'd1);
    repeat (21000 - 9001) tick();
    check("delay_state_late", 32'(o_state), 32'(S_WAIT_SWAP));
    i_enable = 1'b0;
    pulse_vsync();
    check_swap(prev);
    check("delay_end_index", {24'd0, o_frame_index}, 32'd2);
    check("delay_end_idle", 32'(o_state), 32'(S_IDLE));

    // Asynchronous reset in the middle of a load
    i_frame_delay = 24'd0;
    expect_load(1'b0, 8'd2, 24'h104000);
    i_enable = 1'b1;
    wait_stb(5);
    tick();
    load_words(2000, 0, -1);
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    i_enable = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // Restart from frame 0, enable dropped at word 100
    expect_load(1'b1, 8'd0, 24'h100000);
    i_enable = 1'b1;
    wait_stb(5);
    tick();
    load_words(4096, 0, 100);
    tick();
    check("drop_enable_state", 32'(o_state), 32'(S_WAIT_SWAP));
    check("drop_enable_busy", {31'd0, o_busy}, 32'd1);
    prev = o_load_bank;
    pulse_vsync();
    check_swap(prev);
    check("drop_enable_idle", 32'(o_state), 32'(S_IDLE));
    check("drop_enable_not_busy", {31'd0, o_busy}, 32'd0);
    check("drop_enable_index", {24'd0, o_frame_index}, 32'd1);

    // Frame count shrinks below the current index: next swap forces 0
    i_frame_count = 8'd1;
    expect_load(1'b0, 8'd1, 24'h102000);
    i_enable = 1'b1;
    wait_stb(5);
    tick();
    load_words(4096, 0, -1);
    tick();
    i_enable = 1'b0;
    pulse_vsync();
    check("shrink_index_wrap", {24'd0, o_frame_index}, 32'd0);

`ifdef FRAME_SEQUENCER_TIMEOUT_EN
    // Stalled load: watchdog reissues the same frame and latches error
    i_frame_count = 8'd3;
    expect_load(1'b1, 8'd0, 24'h100000);
    expect_load(1'b1, 8'd0, 24'h100000);
    i_enable = 1'b1;
    wait_stb(5);
    check("error_before_timeout", {31'd0, o_error}, 32'd0);
    tick();
    wait_stb((1 << 20) + 10);
    check("error_after_timeout", {31'd0, o_error}, 32'd1);
    i_enable = 1'b0;
    repeat (2) tick();
`else
    check("error_tied_low", {31'd0, o_error}, 32'd0);
`endif

    repeat (5) tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
